upc_checkout_lane: RTL

//  Sequential, parametrised UPC checkout lane. Accepts scanned items over a valid/ready handshake and

---
 rtl/upc_pkg.sv | 17 +
 rtl/upc_checkout_lane_if.sv | 12 +
 rtl/upc_classify.sv | 14 +
 rtl/upc_checkout_lane.sv | 109 ++++++++++
 4 files changed

// File: rtl/upc_pkg.sv
// Shared types and defaults for the UPC checkout lane and its classifier.
package upc_pkg;

    localparam int DEF_CODE_W     = 3;
    localparam int DEF_CNT_W      = 8;
    localparam int DEF_ALARM_HOLD = 16;

    localparam logic [7:0] DEF_EXPENSIVE_MSK = 8'b0011_0001;
    localparam logic [7:0] DEF_DISCOUNT_MSK  = 8'b1110_1100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        ALARM = 2'd2
    } lane_state_t;

endpackage

// File: rtl/upc_checkout_lane_if.sv
// Scanned-item valid/ready handshake between keypad/switch logic and a checkout lane.
interface upc_checkout_lane_if #(
    parameter int CODE_W = upc_pkg::DEF_CODE_W
);
    logic              valid;
    logic              ready;
    logic [CODE_W-1:0] code;
    logic              mark;

    modport master (output valid, code, mark, input ready);
    modport slave  (input valid, code, mark, output ready);
endinterface

// File: rtl/upc_classify.sv
// Combinational mask lookup: item code (+ anti-theft mark) -> {stolen, disc}.
module upc_classify #(
    parameter int                    CODE_W        = upc_pkg::DEF_CODE_W,
    parameter logic [2**CODE_W-1:0]  EXPENSIVE_MSK = upc_pkg::DEF_EXPENSIVE_MSK,
    parameter logic [2**CODE_W-1:0]  DISCOUNT_MSK  = upc_pkg::DEF_DISCOUNT_MSK
) (
    input  logic [CODE_W-1:0] code,
    input  logic              mark,
    output logic              stolen,
    output logic              disc
);
    assign stolen = EXPENSIVE_MSK[code] & ~mark;
    assign disc   = DISCOUNT_MSK[code];
endmodule

// File: rtl/upc_checkout_lane.sv
// Checkout lane FSM with per-transaction saturating counters and a latched theft alarm.
// Optional alarm auto-clear timer is built only when UPC_ALARM_TIMEOUT_EN is defined.
module upc_checkout_lane
    import upc_pkg::*;
#(
    parameter int                    CODE_W        = DEF_CODE_W,
    parameter int                    CNT_W         = DEF_CNT_W,
    parameter logic [2**CODE_W-1:0]  EXPENSIVE_MSK = DEF_EXPENSIVE_MSK,
    parameter logic [2**CODE_W-1:0]  DISCOUNT_MSK  = DEF_DISCOUNT_MSK,
    parameter int                    ALARM_HOLD    = DEF_ALARM_HOLD
) (
    input  logic                 clk,
    input  logic                 reset_n,
    upc_checkout_lane_if.slave   item,
    input  logic                 txn_end,
    input  logic                 alarm_clear,
    output logic                 stolen_alarm,
    output logic                 discount_last,
    output logic [CNT_W-1:0]     item_count,
    output logic [CNT_W-1:0]     discount_count,
    output logic [CNT_W-1:0]     stolen_count,
    output logic [1:0]           lane_state
);
    if (ALARM_HOLD < 1) begin : g_hold_chk
        $error("ALARM_HOLD must be at least 1");
    end

    lane_state_t state;
    logic        stolen, disc, acc;

    upc_classify #(
        .CODE_W(CODE_W), .EXPENSIVE_MSK(EXPENSIVE_MSK), .DISCOUNT_MSK(DISCOUNT_MSK)
    ) u_classify (
        .code(item.code), .mark(item.mark), .stolen(stolen), .disc(disc)
    );

    assign item.ready = (state != ALARM);
    assign acc        = item.valid && (state != ALARM);
    assign lane_state = state;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != {CNT_W{1'b1}})) ? v + 1'b1 : v;
    endfunction

`ifdef UPC_ALARM_TIMEOUT_EN
    localparam int TMR_W = $clog2(ALARM_HOLD + 1);
    logic [TMR_W-1:0] timer;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            stolen_alarm   <= 1'b0;
            discount_last  <= 1'b0;
            item_count     <= '0;
            discount_count <= '0;
            stolen_count   <= '0;
`ifdef UPC_ALARM_TIMEOUT_EN
            timer          <= '0;
`endif
        end else begin
            case (state)
                IDLE, SCAN: begin
                    if (acc) begin
                        // First item of a transaction wipes the previous totals.
                        if (state == IDLE) begin
                            item_count     <= CNT_W'(1);
                            discount_count <= CNT_W'(disc);
                            stolen_count   <= CNT_W'(stolen);
                        end else begin
                            item_count     <= sat_inc(item_count, 1'b1);
                            discount_count <= sat_inc(discount_count, disc);
                            stolen_count   <= sat_inc(stolen_count, stolen);
                        end
                        discount_last <= disc;
                        if (stolen) begin
                            state        <= ALARM;
                            stolen_alarm <= 1'b1;
`ifdef UPC_ALARM_TIMEOUT_EN
                            timer        <= TMR_W'(ALARM_HOLD);
`endif
                        end else if (state == IDLE) begin
                            state <= SCAN;
                        end else if (txn_end) begin
                            state <= IDLE;
                        end
                    end else if (state == SCAN && txn_end) begin
                        state <= IDLE;
                    end
                end
                ALARM: begin
                    if (alarm_clear) begin
                        state        <= SCAN;
                        stolen_alarm <= 1'b0;
`ifdef UPC_ALARM_TIMEOUT_EN
                    end else if (timer <= TMR_W'(1)) begin
                        state        <= SCAN;
                        stolen_alarm <= 1'b0;
                        timer        <= '0;
                    end else begin
                        timer <= timer - 1'b1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
